key_scan_debounce: RTL and testbench

KEY_SCAN_DEBOUNCE -- requirements
Module: key_scan_debounce

---
 rtl/key_scan_pkg.sv | 9 +
 rtl/sync_2ff.sv | 22 ++
 rtl/key_scan_debounce.sv | 80 ++++++++
 tb/tb_key_scan_debounce.sv | 133 +++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared constants, FSM state type and one-hot helper for the key scanner.
package key_scan_pkg;
  localparam int KEY_W = 4;
  localparam int DEBOUNCE_DEFAULT = 16;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESENT, RELEASE} state_t;
  function automatic logic is_onehot(input logic [KEY_W-1:0] k);
    return (k != '0) && ((k & (k - KEY_W'(1))) == '0);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end
  assign o_q = r_sync;
endmodule

// File: rtl/key_scan_debounce.sv
// key_scan_debounce: debounces four push-buttons and hands one single-key press per
// physical press to a valid/ready consumer; multi-key presses raise a one-cycle error.
module key_scan_debounce
  import key_scan_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_raw,
  input  logic             out_ready,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_onehot,
  output logic             multi_err
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [KEY_W-1:0] w_key_sync;
  logic             w_last;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [KEY_W-1:0] r_cand;
  logic             r_valid;
  logic [KEY_W-1:0] r_onehot;
  logic             r_err;
  sync_2ff #(.W(KEY_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (key_raw),
    .o_q (w_key_sync)
  );
  // counter stops at CNT_LAST; the state change happens on that cycle, so it never wraps
  assign w_last = r_cnt == CNT_LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_cand   <= '0;
      r_valid  <= 1'b0;
      r_onehot <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: if (w_key_sync != '0) begin
          r_cand  <= w_key_sync;
          r_cnt   <= '0;
          r_state <= DEBOUNCE;
        end
        DEBOUNCE: if (w_key_sync == '0) r_state <= IDLE;
          else if (w_key_sync != r_cand) begin
            r_cand <= w_key_sync;
            r_cnt  <= '0;
          end else if (!w_last) r_cnt <= r_cnt + CW'(1);
          else if (is_onehot(r_cand)) begin
            r_state  <= PRESENT;
            r_valid  <= 1'b1;
            r_onehot <= r_cand;
          end else begin
            r_state <= RELEASE;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end
        PRESENT: if (r_valid && out_ready) begin
          r_state  <= RELEASE;
          r_valid  <= 1'b0;
          r_onehot <= '0;
          r_cnt    <= '0;
        end
        RELEASE: if (w_key_sync != '0) r_cnt <= '0;
          else if (w_last) r_state <= IDLE;
          else r_cnt <= r_cnt + CW'(1);
        default: r_state <= IDLE;
      endcase
    end
  end
  assign key_valid  = r_valid;
  assign key_onehot = r_onehot;
  assign multi_err  = r_err;
endmodule

// File: tb/tb_key_scan_debounce.sv
// tb_key_scan_debounce: table-driven cycle checks of the debouncer with DEBOUNCE_CYCLES=4,
// plus hand-written reset sequences.
module tb_key_scan_debounce;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_raw = 4'b0000;
  logic       out_ready = 1'b0;
  logic       key_valid;
  logic [3:0] key_onehot;
  logic       multi_err;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  typedef struct {
    logic [3:0] key;
    logic       rdy;
    int         n;
    logic       v;
    logic [3:0] oh;
    logic       err;
  } vec_t;
  vec_t tbl[$];
  key_scan_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .out_ready  (out_ready),
    .key_valid  (key_valid),
    .key_onehot (key_onehot),
    .multi_err  (multi_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask
  task automatic step(input logic [3:0] k, input logic r, input logic rs);
    @(negedge clk);
    key_raw = k;
    out_ready = r;
    rst = rs;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [3:0] oh, input logic e);
    chk({tag, ".valid"}, key_valid, v);
    chk({tag, ".onehot"}, key_onehot, oh);
    chk({tag, ".err"}, multi_err, e);
  endtask
  task automatic add(input logic [3:0] k, input logic r, input int n, input logic v,
                     input logic [3:0] oh, input logic e);
    tbl.push_back('{key: k, rdy: r, n: n, v: v, oh: oh, err: e});
  endtask
  initial begin
    // clean press: valid on edge 7 for one cycle, then released back to IDLE
    add(4'b0000, 0, 3, 0, 4'b0000, 0);
    add(4'b0100, 1, 6, 0, 4'b0000, 0);
    add(4'b0100, 1, 1, 1, 4'b0100, 0);
    add(4'b0100, 1, 5, 0, 4'b0000, 0);
    add(4'b0000, 1, 8, 0, 4'b0000, 0);
    // bounce, then settle
    add(4'b0100, 1, 2, 0, 4'b0000, 0);
    add(4'b0000, 1, 2, 0, 4'b0000, 0);
    add(4'b0100, 1, 2, 0, 4'b0000, 0);
    add(4'b0000, 1, 2, 0, 4'b0000, 0);
    add(4'b0100, 1, 6, 0, 4'b0000, 0);
    add(4'b0100, 1, 1, 1, 4'b0100, 0);
    add(4'b0100, 1, 3, 0, 4'b0000, 0);
    add(4'b0000, 1, 8, 0, 4'b0000, 0);
    // backpressure with release while presenting
    add(4'b0001, 0, 6, 0, 4'b0000, 0);
    add(4'b0001, 0, 1, 1, 4'b0001, 0);
    add(4'b0001, 0, 9, 1, 4'b0001, 0);
    add(4'b0000, 0, 11, 1, 4'b0001, 0);
    add(4'b0000, 1, 1, 0, 4'b0000, 0);
    add(4'b0000, 1, 8, 0, 4'b0000, 0);
    // multi-key error, then a fresh single press
    add(4'b1011, 1, 6, 0, 4'b0000, 0);
    add(4'b1011, 1, 1, 0, 4'b0000, 1);
    add(4'b1011, 1, 10, 0, 4'b0000, 0);
    add(4'b0000, 1, 8, 0, 4'b0000, 0);
    add(4'b0010, 1, 6, 0, 4'b0000, 0);
    add(4'b0010, 1, 1, 1, 4'b0010, 0);
    add(4'b0000, 1, 8, 0, 4'b0000, 0);
    // long hold, short release glitch, full release, re-press
    add(4'b1000, 1, 6, 0, 4'b0000, 0);
    add(4'b1000, 1, 1, 1, 4'b1000, 0);
    add(4'b1000, 1, 93, 0, 4'b0000, 0);
    add(4'b0000, 1, 2, 0, 4'b0000, 0);
    add(4'b1000, 1, 12, 0, 4'b0000, 0);
    add(4'b0000, 1, 8, 0, 4'b0000, 0);
    add(4'b1000, 1, 6, 0, 4'b0000, 0);
    add(4'b1000, 1, 1, 1, 4'b1000, 0);
    add(4'b0000, 1, 8, 0, 4'b0000, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 4'b0000, 1'b0);
    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        step(tbl[i].key, tbl[i].rdy, 1'b0);
        chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].oh, tbl[i].err);
      end
    end
    // reset mid-DEBOUNCE restarts the full debounce
    repeat (4) step(4'b0100, 1, 0);
    step(4'b0100, 1, 1);
    chk_out("rst_deb", 1'b0, 4'b0000, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      step(4'b0100, 1, 0);
      chk_out($sformatf("after_rst_deb%0d", j), j == 7, (j == 7) ? 4'b0100 : 4'b0000, 1'b0);
    end
    repeat (8) step(4'b0000, 1, 0);
    // reset while presenting: outputs clear without a clock edge, then a fresh press
    for (int j = 1; j <= 7; j++) step(4'b0010, 0, 0);
    chk_out("present", 1'b1, 4'b0010, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_out("rst_async", 1'b0, 4'b0000, 1'b0);
    step(4'b0010, 1, 1);
    chk_out("rst_held", 1'b0, 4'b0000, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      step(4'b0010, 1, 0);
      chk_out($sformatf("after_rst_pr%0d", j), j == 7, (j == 7) ? 4'b0010 : 4'b0000, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
